// File: rtl/fc_mover_pkg.sv
// Shared types and constants for the fully-connected BRAM data mover.
// Pipeline depth is address-issue to write-strobe, in cycles.
package fc_mover_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic MODE_ELEM = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  localparam int PIPE_LAT = 3;

endpackage

// File: rtl/fc_mac_lane.sv
// One signed MAC lane: registered product, then add/accumulate fused with ReLU.
// Result and valid appear two cycles after the inputs are presented.
module fc_mac_lane
  import fc_mover_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int RES_W = 36
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  input  logic                    i_first,
  input  logic                    i_last,
  input  logic                    i_mode,
  input  logic                    i_relu,
  input  logic signed [IN_W-1:0]  i_node,
  input  logic signed [IN_W-1:0]  i_wegt,
  input  logic signed [IN_W-1:0]  i_bias,
  output logic signed [RES_W-1:0] o_result,
  output logic                    o_valid
);

  logic signed [2*IN_W-1:0] r_prod;
  logic signed [IN_W-1:0]   r_bias;
  logic                     r_v1;
  logic                     r_first1;
  logic                     r_last1;
  logic signed [RES_W-1:0]  r_acc;
  logic signed [RES_W-1:0]  r_res;
  logic                     r_vout;

  logic signed [RES_W-1:0]  w_prod_ext;
  logic signed [RES_W-1:0]  w_bias_ext;
  logic signed [RES_W-1:0]  w_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prod   <= '0;
      r_bias   <= '0;
      r_v1     <= 1'b0;
      r_first1 <= 1'b0;
      r_last1  <= 1'b0;
    end else begin
      r_prod   <= i_node * i_wegt;
      r_bias   <= i_bias;
      r_v1     <= i_valid;
      r_first1 <= i_first;
      r_last1  <= i_last;
    end
  end

  assign w_prod_ext = RES_W'(r_prod);
  assign w_bias_ext = RES_W'(r_bias);

  // Bias enters accumulate mode only with the first element, which also restarts the sum.
  always_comb begin
    w_sum = w_prod_ext + w_bias_ext;
    if (i_mode == MODE_ACC && !r_first1) begin
      w_sum = r_acc + w_prod_ext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_res  <= '0;
      r_vout <= 1'b0;
    end else begin
      r_vout <= r_v1 && (i_mode == MODE_ELEM || r_last1);
      if (r_v1) begin
        r_acc <= w_sum;
        r_res <= (i_relu && w_sum[RES_W-1]) ? '0 : w_sum;
      end
    end
  end

  assign o_result = r_res;
  assign o_valid  = r_vout;

endmodule

// File: rtl/fc_data_mover_wb.sv
// Streams node/weight/bias words from three BRAMs through NUM_CORE MAC lanes
// and writes packed results to a fourth BRAM; lane 0 sits in the MSB slice.
module fc_data_mover_wb
  import fc_mover_pkg::*;
#(
  parameter int NUM_CORE = 4,
  parameter int IN_W     = 9,
  parameter int RES_W    = 36,
  parameter int AWIDTH   = 12,
  parameter int CNT_BIT  = 13,
  localparam int DWIDTH  = NUM_CORE * IN_W,
  localparam int OWIDTH  = NUM_CORE * RES_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_run,
  input  logic [CNT_BIT-1:0] i_num_cnt,
  input  logic               i_mode,
  input  logic               i_relu_en,
  input  logic [AWIDTH-1:0]  i_rd_base,
  input  logic [AWIDTH-1:0]  i_wr_base,
  output logic               o_idle,
  output logic               o_read,
  output logic               o_write,
  output logic               o_done,
  output logic [AWIDTH-1:0]  addr_b0,
  output logic               ce_b0,
  input  logic [DWIDTH-1:0]  q_b0,
  output logic [AWIDTH-1:0]  addr_b1,
  output logic               ce_b1,
  input  logic [DWIDTH-1:0]  q_b1,
  output logic [AWIDTH-1:0]  addr_b2,
  output logic               ce_b2,
  input  logic [DWIDTH-1:0]  q_b2,
  output logic [AWIDTH-1:0]  addr_b3,
  output logic               ce_b3,
  output logic               we_b3,
  output logic [OWIDTH-1:0]  d_b3
);

  state_t               r_state;
  state_t               w_next;
  logic [CNT_BIT-1:0]   r_num;
  logic                 r_mode;
  logic                 r_relu;
  logic [AWIDTH-1:0]    r_rd_base;
  logic [AWIDTH-1:0]    r_wr_base;
  logic [CNT_BIT-1:0]   r_rd_cnt;
  logic [CNT_BIT-1:0]   r_wr_cnt;
  logic                 r_iss_v;
  logic                 r_iss_first;
  logic                 r_iss_last;

  logic                 w_accept;
  logic                 w_reading;
  logic                 w_last_rd;
  logic                 w_wr_fire;
  logic                 w_last_wr;
  logic [NUM_CORE-1:0]  w_lane_v;
  logic [AWIDTH-1:0]    w_rd_addr;

  assign w_accept  = (r_state == S_IDLE) && i_run;
  assign w_reading = (r_state == S_READ);
  assign w_last_rd = (r_rd_cnt == r_num - CNT_BIT'(1));
  assign w_wr_fire = &w_lane_v;
  assign w_last_wr = w_wr_fire && (r_mode == MODE_ACC || r_wr_cnt == r_num - CNT_BIT'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_run) w_next = (i_num_cnt == '0) ? S_DONE : S_READ;
      S_READ:  if (w_last_rd) w_next = S_DRAIN;
      S_DRAIN: if (w_last_wr) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_num     <= '0;
      r_mode    <= MODE_ELEM;
      r_relu    <= 1'b0;
      r_rd_base <= '0;
      r_wr_base <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
    end else if (w_accept) begin
      r_num     <= i_num_cnt;
      r_mode    <= i_mode;
      r_relu    <= i_relu_en;
      r_rd_base <= i_rd_base;
      r_wr_base <= i_wr_base;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
    end else begin
      if (w_reading && !w_last_rd) r_rd_cnt <= r_rd_cnt + CNT_BIT'(1);
      if (w_wr_fire) r_wr_cnt <= r_wr_cnt + CNT_BIT'(1);
    end
  end

  // Element markers follow the address by one cycle so they line up with q_bx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_iss_v     <= 1'b0;
      r_iss_first <= 1'b0;
      r_iss_last  <= 1'b0;
    end else begin
      r_iss_v     <= w_reading;
      r_iss_first <= w_reading && (r_rd_cnt == '0);
      r_iss_last  <= w_reading && w_last_rd;
    end
  end

  for (genvar g = 0; g < NUM_CORE; g++) begin : g_lane
    fc_mac_lane #(
      .IN_W  (IN_W),
      .RES_W (RES_W)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_valid  (r_iss_v),
      .i_first  (r_iss_first),
      .i_last   (r_iss_last),
      .i_mode   (r_mode),
      .i_relu   (r_relu),
      .i_node   (q_b0[DWIDTH-1-g*IN_W -: IN_W]),
      .i_wegt   (q_b1[DWIDTH-1-g*IN_W -: IN_W]),
      .i_bias   (q_b2[DWIDTH-1-g*IN_W -: IN_W]),
      .o_result (d_b3[OWIDTH-1-g*RES_W -: RES_W]),
      .o_valid  (w_lane_v[g])
    );
  end

  assign w_rd_addr = w_reading ? (r_rd_base + r_rd_cnt[AWIDTH-1:0]) : '0;
  assign addr_b0   = w_rd_addr;
  assign addr_b1   = w_rd_addr;
  assign addr_b2   = w_rd_addr;
  assign ce_b0     = w_reading;
  assign ce_b1     = w_reading;
  assign ce_b2     = w_reading;

  assign addr_b3 = w_wr_fire ? (r_wr_base + r_wr_cnt[AWIDTH-1:0]) : '0;
  assign ce_b3   = w_wr_fire;
  assign we_b3   = w_wr_fire;

  assign o_idle  = (r_state == S_IDLE);
  assign o_read  = w_reading;
  assign o_write = w_reading || (r_state == S_DRAIN);
  assign o_done  = (r_state == S_DONE);

endmodule

// File: tb/tb_fc_data_mover_wb.sv
// Directed bench for fc_data_mover_wb: default 4-lane build plus a 2-lane
// IN_W=8 build used to confirm result lane placement in d_b3.
module tb_fc_data_mover_wb;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_run;
  logic [12:0]  i_num_cnt;
  logic         i_mode;
  logic         i_relu_en;
  logic [11:0]  i_rd_base;
  logic [11:0]  i_wr_base;
  logic         o_idle, o_read, o_write, o_done;
  logic [11:0]  addr_b0, addr_b1, addr_b2, addr_b3;
  logic         ce_b0, ce_b1, ce_b2, ce_b3, we_b3;
  logic [35:0]  q_b0, q_b1, q_b2;
  logic [143:0] d_b3;

  logic         run2;
  logic         idle2, read2, write2, done2;
  logic [11:0]  a2_b0, a2_b1, a2_b2, a2_b3;
  logic         c2_b0, c2_b1, c2_b2, c2_b3, w2_b3;
  logic [15:0]  q2_b0, q2_b1, q2_b2;
  logic [71:0]  d2_b3;

  logic [35:0]  nodeMem [4096];
  logic [35:0]  wegtMem [4096];
  logic [35:0]  biasMem [4096];

  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           runCyc;
  int           doneCyc;
  bit           ceSeen;
  int           wrAddr[$];
  int           wrCyc[$];
  logic [143:0] wrData[$];
  int           rdAddr[$];
  logic [71:0]  wr2Data[$];

  always #5 clk = ~clk;

  fc_data_mover_wb dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt),
    .i_mode(i_mode), .i_relu_en(i_relu_en), .i_rd_base(i_rd_base),
    .i_wr_base(i_wr_base), .o_idle(o_idle), .o_read(o_read),
    .o_write(o_write), .o_done(o_done),
    .addr_b0(addr_b0), .ce_b0(ce_b0), .q_b0(q_b0),
    .addr_b1(addr_b1), .ce_b1(ce_b1), .q_b1(q_b1),
    .addr_b2(addr_b2), .ce_b2(ce_b2), .q_b2(q_b2),
    .addr_b3(addr_b3), .ce_b3(ce_b3), .we_b3(we_b3), .d_b3(d_b3)
  );

  fc_data_mover_wb #(.NUM_CORE(2), .IN_W(8)) dut2 (
    .clk(clk), .reset(reset), .i_run(run2), .i_num_cnt(13'd1),
    .i_mode(1'b0), .i_relu_en(1'b0), .i_rd_base(12'd0),
    .i_wr_base(12'd7), .o_idle(idle2), .o_read(read2),
    .o_write(write2), .o_done(done2),
    .addr_b0(a2_b0), .ce_b0(c2_b0), .q_b0(q2_b0),
    .addr_b1(a2_b1), .ce_b1(c2_b1), .q_b1(q2_b1),
    .addr_b2(a2_b2), .ce_b2(c2_b2), .q_b2(q2_b2),
    .addr_b3(a2_b3), .ce_b3(c2_b3), .we_b3(w2_b3), .d_b3(d2_b3)
  );

  // BRAM models with one cycle of read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ce_b0) q_b0 <= nodeMem[addr_b0];
    if (ce_b1) q_b1 <= wegtMem[addr_b1];
    if (ce_b2) q_b2 <= biasMem[addr_b2];
    if (c2_b0) q2_b0 <= 16'h03FF;
    if (c2_b1) q2_b1 <= 16'h0407;
    if (c2_b2) q2_b2 <= 16'h0100;
  end

  always @(negedge clk) begin
    if (ce_b0 || ce_b1 || ce_b2 || ce_b3) ceSeen = 1'b1;
    if (ce_b0) rdAddr.push_back(int'(addr_b0));
    if (ce_b3 && we_b3) begin
      wrAddr.push_back(int'(addr_b3));
      wrData.push_back(d_b3);
      wrCyc.push_back(cyc);
    end
    if (c2_b3 && w2_b3) wr2Data.push_back(d2_b3);
  end

  function automatic logic [35:0] rep9(int v);
    logic [8:0] t;
    t = v[8:0];
    return {4{t}};
  endfunction

  function automatic logic [143:0] rep36(int v);
    logic [35:0] t;
    t = 36'(v);
    return {4{t}};
  endfunction

  task automatic checkOutput(string tag, logic [143:0] obs, logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearLogs();
    wrAddr.delete();
    wrData.delete();
    wrCyc.delete();
    rdAddr.delete();
    ceSeen = 1'b0;
  endtask

  task automatic applyStimulus(int n, logic mode, logic relu, int rdb, int wrb);
    @(negedge clk);
    i_num_cnt = 13'(n);
    i_mode    = mode;
    i_relu_en = relu;
    i_rd_base = 12'(rdb);
    i_wr_base = 12'(wrb);
    i_run     = 1'b1;
    runCyc    = cyc;
    @(posedge clk);
    #1 i_run = 1'b0;
  endtask

  task automatic waitDone(output int dc);
    dc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_done) begin
        dc = cyc;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; i_run = 1'b0; run2 = 1'b0; i_num_cnt = '0; i_mode = 1'b0;
    i_relu_en = 1'b0; i_rd_base = '0; i_wr_base = '0;
    for (int a = 0; a < 4096; a++) begin
      nodeMem[a] = '0; wegtMem[a] = '0; biasMem[a] = '0;
    end
    #12;
    checkOutput("rst_idle", o_idle, 1);
    checkOutput("rst_read", o_read, 0);
    checkOutput("rst_write", o_write, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_ce_b0", ce_b0, 0);
    checkOutput("rst_ce_b3", ce_b3, 0);
    checkOutput("rst_we_b3", we_b3, 0);
    checkOutput("rst_addr_b0", addr_b0, 0);
    checkOutput("rst_addr_b3", addr_b3, 0);
    checkOutput("rst_d_b3", d_b3, 0);
    @(negedge clk); reset = 1'b0;

    // Element-wise: 3 * -2 + 5 = -1 in every lane.
    for (int k = 0; k < 4; k++) begin
      nodeMem[k] = rep9(3); wegtMem[k] = rep9(-2); biasMem[k] = rep9(5);
    end
    clearLogs();
    applyStimulus(4, 1'b0, 1'b0, 0, 16);
    waitDone(doneCyc);
    checkOutput("elem_nwr", wrAddr.size(), 4);
    if (wrAddr.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("elem_addr%0d", k), wrAddr[k], 16 + k);
        checkOutput($sformatf("elem_data%0d", k), wrData[k], rep36(-1));
      end
      checkOutput("elem_first_lat", wrCyc[0], runCyc + 4);
      checkOutput("elem_done_cyc", doneCyc, wrCyc[3] + 1);
    end

    // Accumulate: sum(k+1, k=0..7) + 10 = 46; only element-0 bias counts.
    for (int k = 0; k < 8; k++) begin
      nodeMem[100 + k] = rep9(k + 1); wegtMem[100 + k] = rep9(1);
      biasMem[100 + k] = rep9(k == 0 ? 10 : 99);
    end
    clearLogs();
    applyStimulus(8, 1'b1, 1'b0, 100, 200);
    waitDone(doneCyc);
    checkOutput("acc_nwr", wrAddr.size(), 1);
    if (wrAddr.size() == 1) begin
      checkOutput("acc_addr", wrAddr[0], 200);
      checkOutput("acc_data", wrData[0], rep36(46));
      checkOutput("acc_done_cyc", doneCyc, wrCyc[0] + 1);
    end

    // ReLU on/off: -5 * 4 + 0 = -20.
    for (int k = 0; k < 2; k++) begin
      nodeMem[300 + k] = rep9(-5); wegtMem[300 + k] = rep9(4); biasMem[300 + k] = rep9(0);
    end
    clearLogs();
    applyStimulus(2, 1'b0, 1'b1, 300, 400);
    waitDone(doneCyc);
    checkOutput("relu_on_nwr", wrAddr.size(), 2);
    if (wrAddr.size() == 2) checkOutput("relu_on_data", wrData[1], 0);
    clearLogs();
    applyStimulus(2, 1'b0, 1'b0, 300, 400);
    waitDone(doneCyc);
    checkOutput("relu_off_nwr", wrAddr.size(), 2);
    if (wrAddr.size() == 2) checkOutput("relu_off_data", wrData[0], {4{36'hFFFFFFFEC}});

    // Zero-length transfer: done quickly, no BRAM strobes at all.
    clearLogs();
    applyStimulus(0, 1'b0, 1'b0, 0, 0);
    waitDone(doneCyc);
    checkOutput("n0_done_fast", (doneCyc >= 0 && doneCyc <= runCyc + 2), 1);
    repeat (3) @(negedge clk);
    checkOutput("n0_no_ce", ceSeen, 0);
    checkOutput("n0_idle", o_idle, 1);

    // Read-address wrap plus an ignored run request during READ.
    clearLogs();
    applyStimulus(4, 1'b0, 1'b0, 4094, 50);
    @(negedge clk);
    i_num_cnt = 13'd1; i_run = 1'b1;
    @(negedge clk);
    i_run = 1'b0;
    waitDone(doneCyc);
    checkOutput("wrap_nrd", rdAddr.size(), 4);
    if (rdAddr.size() == 4) begin
      checkOutput("wrap_rd0", rdAddr[0], 4094);
      checkOutput("wrap_rd1", rdAddr[1], 4095);
      checkOutput("wrap_rd2", rdAddr[2], 0);
      checkOutput("wrap_rd3", rdAddr[3], 1);
    end
    checkOutput("wrap_nwr", wrAddr.size(), 4);
    if (wrAddr.size() == 4) checkOutput("wrap_last_waddr", wrAddr[3], 53);
    repeat (3) @(negedge clk);
    checkOutput("wrap_no_rerun", o_idle, 1);

    // Reset while draining, then a clean rerun.
    clearLogs();
    applyStimulus(4, 1'b0, 1'b0, 0, 16);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!o_read && o_write) break;
    end
    checkOutput("drain_reached", (!o_read && o_write), 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_idle", o_idle, 1);
    checkOutput("mid_rst_write", o_write, 0);
    checkOutput("mid_rst_ce_b3", ce_b3, 0);
    checkOutput("mid_rst_d_b3", d_b3, 0);
    checkOutput("mid_rst_addr_b3", addr_b3, 0);
    @(negedge clk); reset = 1'b0;
    clearLogs();
    applyStimulus(4, 1'b0, 1'b0, 0, 16);
    waitDone(doneCyc);
    checkOutput("rerun_nwr", wrAddr.size(), 4);
    if (wrAddr.size() == 4) begin
      checkOutput("rerun_addr3", wrAddr[3], 19);
      checkOutput("rerun_data0", wrData[0], rep36(-1));
    end

    // Two-lane build: lane0 = 3*4+1 = 13 in the upper slice, lane1 = -1*7+0 = -7 below.
    wr2Data.delete();
    @(negedge clk); run2 = 1'b1;
    @(negedge clk); run2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done2) break;
    end
    checkOutput("lane2_nwr", wr2Data.size(), 1);
    if (wr2Data.size() == 1) begin
      checkOutput("lane2_hi", wr2Data[0][71:36], 36'h00000000D);
      checkOutput("lane2_lo", wr2Data[0][35:0], 36'hFFFFFFFF9);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
